snake_dir_ctrl: RTL and testbench

Direction-command controller between the debounced button inputs and the Snake game logic. It turns the five clean button levels into rising-edge events and runs the game's run/pause/over state machine. It also keeps a small FIFO of pending turns, filtering out duplicate and 180° reversals, and applies at most one turn per game step tick. This lets fast key sequences entered between two steps take effect on consecutive steps instead of being lost.

---
 rtl/snake_dir_ctrl.sv | 138 +++++++++++++
 tb/tb_snake_dir_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// Snake direction-command controller: button edge detection, run/pause/over FSM,
// and a small queue of pending turns that feeds the heading one turn per game step.
module snake_dir_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_up,
  input  logic                     btn_right,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_pause,
  input  logic                     step_tick,
  input  logic                     game_over,
  output logic [1:0]               dir,
  output logic                     dir_changed,
  output logic                     running,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Bit order {pause, left, down, right, up}
  logic [4:0] btn_p0, btn_p1, ev;
  logic       tick_p0, over_p0;

  logic [1:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, tail_ptr;

  logic       dir_ev, push, pop, full, accept;
  logic [1:0] cand, ref_dir;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d + 2'd2;
  endfunction

  function automatic logic is_turn(input logic [1:0] c, input logic [1:0] r);
    return (c != r) && (c != opposite(r));
  endfunction

  // Stage p0: input capture; p1: previous level. Both start high so held buttons stay silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_p0  <= '1;
      btn_p1  <= '1;
      tick_p0 <= 1'b0;
      over_p0 <= 1'b0;
    end else begin
      btn_p0  <= {btn_pause, btn_left, btn_down, btn_right, btn_up};
      btn_p1  <= btn_p0;
      tick_p0 <= step_tick;
      over_p0 <= game_over;
    end
  end

  assign ev       = btn_p0 & ~btn_p1;
  assign dir_ev   = |ev[3:0];
  assign full     = (q_count == FULL_CNT);
  assign tail_ptr = wr_ptr - PTR_ONE;
  assign ref_dir  = (q_count != '0) ? fifo_mem[tail_ptr] : dir;
  assign accept   = dir_ev && is_turn(cand, ref_dir);

  always_comb begin
    cand = 2'd3;
    if (ev[0])      cand = 2'd0;
    else if (ev[1]) cand = 2'd1;
    else if (ev[2]) cand = 2'd2;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        push = accept && !full;
        if (ev[4] || dir_ev) state_nxt = RUN;
      end
      RUN: begin
        pop  = tick_p0 && (q_count != '0);
        push = accept && (!full || pop);
        if (over_p0)    state_nxt = OVER;
        else if (ev[4]) state_nxt = PAUSED;
      end
      PAUSED: begin
        if (over_p0)    state_nxt = OVER;
        else if (ev[4]) state_nxt = RUN;
      end
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: state, queue bookkeeping and heading update
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      dir         <= 2'd1;
      dir_changed <= 1'b0;
    end else begin
      state       <= state_nxt;
      dir_changed <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dir    <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + CNT_ONE;
        2'b01:   q_count <= q_count - CNT_ONE;
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cand;
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl: a vector table of button/tick pulses with
// expected outputs, plus hand sequences around reset.
module tb_snake_dir_ctrl;

  localparam int DEPTH = 2;
  localparam int NV    = 31;

  localparam logic [6:0] U = 7'd1, R = 7'd2, D = 7'd4, L = 7'd8;
  localparam logic [6:0] P = 7'd16, T = 7'd32, O = 7'd64, N = 7'd0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 0, btn_right = 0, btn_down = 0, btn_left = 0, btn_pause = 0;
  logic step_tick = 0, game_over = 0;
  logic [1:0] dir;
  logic dir_changed, running;
  logic [$clog2(DEPTH):0] q_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0] stim;   // {over, tick, pause, left, down, right, up}
    logic [1:0] dir;
    logic       chg;
    logic       run;
    logic [1:0] qc;
  } vec_t;

  vec_t vecs [NV];

  snake_dir_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down),
    .btn_left(btn_left), .btn_pause(btn_pause),
    .step_tick(step_tick), .game_over(game_over),
    .dir(dir), .dir_changed(dir_changed), .running(running), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [6:0] s, input logic [1:0] d,
                              input logic c, input logic r, input logic [1:0] q);
    vec_t v;
    v.stim = s; v.dir = d; v.chg = c; v.run = r; v.qc = q;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int d, input int c, input int r, input int q);
    chk({tag, ".dir"}, int'(dir), d);
    chk({tag, ".dir_changed"}, int'(dir_changed), c);
    chk({tag, ".running"}, int'(running), r);
    chk({tag, ".q_count"}, int'(q_count), q);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] s);
    btn_up    = s[0];
    btn_right = s[1];
    btn_down  = s[2];
    btn_left  = s[3];
    btn_pause = s[4];
    step_tick = s[5];
    game_over = s[6];
  endtask

  // One-cycle pulse, then one idle cycle so its effect is visible.
  task automatic apply(input logic [6:0] s);
    drive(s);
    clk1();
    drive(N);
    clk1();
  endtask

  initial begin
    vecs[0]  = mk(U,     2'd1, 1'b0, 1'b1, 2'd1); // IDLE -> RUN, up queued
    vecs[1]  = mk(T,     2'd0, 1'b1, 1'b1, 2'd0);
    vecs[2]  = mk(N,     2'd0, 1'b0, 1'b1, 2'd0); // dir_changed single pulse
    vecs[3]  = mk(R,     2'd0, 1'b0, 1'b1, 2'd1);
    vecs[4]  = mk(T,     2'd1, 1'b1, 1'b1, 2'd0);
    vecs[5]  = mk(L,     2'd1, 1'b0, 1'b1, 2'd0); // reversal
    vecs[6]  = mk(R,     2'd1, 1'b0, 1'b1, 2'd0); // duplicate
    vecs[7]  = mk(D,     2'd1, 1'b0, 1'b1, 2'd1);
    vecs[8]  = mk(L,     2'd1, 1'b0, 1'b1, 2'd2); // ref is tail (down)
    vecs[9]  = mk(T,     2'd2, 1'b1, 1'b1, 2'd1);
    vecs[10] = mk(T,     2'd3, 1'b1, 1'b1, 2'd0);
    vecs[11] = mk(U,     2'd3, 1'b0, 1'b1, 2'd1);
    vecs[12] = mk(L,     2'd3, 1'b0, 1'b1, 2'd2);
    vecs[13] = mk(D,     2'd3, 1'b0, 1'b1, 2'd2); // full, dropped
    vecs[14] = mk(D | T, 2'd0, 1'b1, 1'b1, 2'd2); // full + pop: accepted
    vecs[15] = mk(T,     2'd3, 1'b1, 1'b1, 2'd1);
    vecs[16] = mk(T,     2'd2, 1'b1, 1'b1, 2'd0);
    vecs[17] = mk(T,     2'd2, 1'b0, 1'b1, 2'd0); // empty tick
    vecs[18] = mk(R,     2'd2, 1'b0, 1'b1, 2'd1);
    vecs[19] = mk(T,     2'd1, 1'b1, 1'b1, 2'd0);
    vecs[20] = mk(U | L, 2'd1, 1'b0, 1'b1, 2'd1); // priority: up wins
    vecs[21] = mk(P,     2'd1, 1'b0, 1'b0, 2'd1);
    vecs[22] = mk(D,     2'd1, 1'b0, 1'b0, 2'd1); // ignored while paused
    vecs[23] = mk(T,     2'd1, 1'b0, 1'b0, 2'd1);
    vecs[24] = mk(P,     2'd1, 1'b0, 1'b1, 2'd1); // resume, queue intact
    vecs[25] = mk(T,     2'd0, 1'b1, 1'b1, 2'd0);
    vecs[26] = mk(P,     2'd0, 1'b0, 1'b0, 2'd0);
    vecs[27] = mk(P,     2'd0, 1'b0, 1'b1, 2'd0);
    vecs[28] = mk(P | O, 2'd0, 1'b0, 1'b0, 2'd0); // over beats pause
    vecs[29] = mk(P,     2'd0, 1'b0, 1'b0, 2'd0); // OVER stays
    vecs[30] = mk(R | T, 2'd0, 1'b0, 1'b0, 2'd0);

    // Reset values, during and after reset
    drive(N);
    reset = 1'b1;
    repeat (3) clk1();
    chk_all("rst_hold", 1, 0, 0, 0);
    reset = 1'b0;
    clk1();
    chk_all("rst_rel", 1, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].stim);
      chk_all($sformatf("vec%0d", i), vecs[i].dir, vecs[i].chg, vecs[i].run, vecs[i].qc);
    end

    // Button held through reset release produces no event
    reset = 1'b1;
    btn_right = 1'b1;
    repeat (2) clk1();
    reset = 1'b0;
    clk1();
    chk_all("held_rst", 1, 0, 0, 0);
    repeat (2) clk1();
    chk_all("held_after", 1, 0, 0, 0);
    btn_right = 1'b0;
    clk1();

    // Fill the queue, then reset on the edge where a pop would have happened
    apply(D);
    chk_all("refill_d", 1, 0, 1, 1);
    apply(L);
    chk_all("refill_l", 1, 0, 1, 2);
    step_tick = 1'b1;
    clk1();
    step_tick = 1'b0;
    reset = 1'b1;
    clk1();
    chk_all("midop_rst", 1, 0, 0, 0);
    reset = 1'b0;
    clk1();
    chk_all("midop_rel", 1, 0, 0, 0);

    // Left from IDLE starts the game but is a reversal of the initial heading
    apply(L);
    chk_all("idle_left", 1, 0, 1, 0);
    apply(T);
    chk_all("idle_left_tick", 1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
